// File: rtl/sample_sum_pkg.sv
// Shared state encoding and width helpers for the multi-channel sample summer.
// Pure declarations: no latency, no flow control.
package sample_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_idx_w(input int sample_num);
        return (sample_num > 1) ? $clog2(sample_num) : 1;
    endfunction

    function automatic int calc_sum_w(input int data_w, input int sample_num);
        return data_w + 1 + $clog2(sample_num + 1);
    endfunction

endpackage

// File: rtl/sample_sum_ch.sv
// One channel: presample ring with running sum, latched baseline, window integrator and peak tracker.
// Latency: results settle one cycle after the last window sample; no local backpressure, the top FSM holds it.
module sample_sum_ch #(
    parameter int DATA_W        = 12,
    parameter int PRESAMPLE_NUM = 4,
    parameter int IDX_W         = 5,
    parameter int SUM_W         = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              start,
    input  logic              acc_en,
    input  logic [IDX_W-1:0]  idx,
    output logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] peak,
    output logic [IDX_W-1:0]  peak_idx
);

    localparam int LOG_PN = $clog2(PRESAMPLE_NUM);
    localparam int RS_W   = DATA_W + LOG_PN;

    logic [DATA_W-1:0] ring [PRESAMPLE_NUM];
    logic [RS_W-1:0]   run_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PRESAMPLE_NUM; i++) begin
                ring[i] <= '0;
            end
            run_sum  <= '0;
            base     <= '0;
            sum      <= '0;
            peak     <= '0;
            peak_idx <= '0;
        end else begin
            // ring[PRESAMPLE_NUM-1] is the oldest presample and leaves the running sum this cycle
            ring[0] <= sample;
            for (int i = 1; i < PRESAMPLE_NUM; i++) begin
                ring[i] <= ring[i-1];
            end
            run_sum <= run_sum + RS_W'(sample) - RS_W'(ring[PRESAMPLE_NUM-1]);

            if (start) begin
                base <= DATA_W'(run_sum >> LOG_PN);
                sum  <= '0;
            end

            if (acc_en) begin
                sum <= sum + SUM_W'(sample) - SUM_W'(base);
                if ((idx == '0) || (sample > peak)) begin
                    peak     <= sample;
                    peak_idx <= idx;
                end
            end
        end
    end

endmodule

// File: rtl/sample_sum_mc.sv
// Multi-channel triggered baseline-subtracted window summer with peak finder, NCH channels in lock-step.
// Latency: out_valid SAMPLE_NUM+1 cycles after L0; result held in DONE until out_ready, L0 dropped while busy.
module sample_sum_mc
    import sample_sum_pkg::*;
#(
    parameter  int NCH           = 4,
    parameter  int DATA_W        = 12,
    parameter  int PRESAMPLE_NUM = 4,
    parameter  int SAMPLE_NUM    = 24,
    localparam int IDX_W         = calc_idx_w(SAMPLE_NUM),
    localparam int SUM_W         = calc_sum_w(DATA_W, SAMPLE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  L0,
    input  logic [NCH*DATA_W-1:0] data_in,
    output logic                  busy,
    output logic                  l0_drop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*SUM_W-1:0]  sum_out,
    output logic [NCH*DATA_W-1:0] base_out,
    output logic [NCH*DATA_W-1:0] peak_out,
    output logic [NCH*IDX_W-1:0]  peak_idx
);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             start;
    logic             acc_en;
    logic             last;

    assign start  = (state == IDLE) && L0;
    assign acc_en = (state == ACC);
    assign last   = (cnt == IDX_W'(SAMPLE_NUM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            l0_drop   <= 1'b0;
        end else begin
            l0_drop <= L0 && (state != IDLE);
            case (state)
                IDLE: begin
                    if (L0) begin
                        state <= ACC;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ACC: begin
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        sample_sum_ch #(
            .DATA_W        (DATA_W),
            .PRESAMPLE_NUM (PRESAMPLE_NUM),
            .IDX_W         (IDX_W),
            .SUM_W         (SUM_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .sample   (data_in[c*DATA_W +: DATA_W]),
            .start    (start),
            .acc_en   (acc_en),
            .idx      (cnt),
            .sum      (sum_out[c*SUM_W +: SUM_W]),
            .base     (base_out[c*DATA_W +: DATA_W]),
            .peak     (peak_out[c*DATA_W +: DATA_W]),
            .peak_idx (peak_idx[c*IDX_W +: IDX_W])
        );
    end

endmodule

// File: doc/sample_sum_mc.md
# sample_sum_mc

Multi-channel, parametrised successor to the single-channel sample summer in the ADC readout path. On each L0 trigger it does three things per channel. It latches a baseline from the presamples that preceded the trigger. It then integrates a fixed window of baseline-subtracted ADC samples and tracks the peak sample and its position. Results are presented to the event builder through a valid/ready handshake. It sits between the ADC deserialiser outputs and the FEC readout buffer.

## Interface
- `NCH`, 4: number of ADC channels processed in lock-step.
- `DATA_W`, 12: ADC sample width, unsigned.
- `PRESAMPLE_NUM`, 4: baseline window length; power of two, 1..64.
- `SAMPLE_NUM`, 24: integration window length, 1..1024.
- Derived: `IDX_W` = max(1, $clog2(`SAMPLE_NUM`)); `SUM_W` = `DATA_W` + 1 + $clog2(`SAMPLE_NUM`+1).

Ports:
- `clk`  in  1  ADC sample clock; one sample per channel per cycle.
- `rst`  in  1  synchronous, active-high reset.
- `L0`  in  1  trigger, sampled on `clk`; level is evaluated every cycle.
- `data_in`  in  `NCH*DATA_W`  channel c occupies bits [c*`DATA_W` +: `DATA_W`].
- `busy`  out  1  high whenever the state is not IDLE.
- `l0_drop`  out  1  one-cycle pulse when `L0` is high while not IDLE.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `sum_out`  out  `NCH*SUM_W`  signed sum of (sample − baseline) over the window.
- `base_out`  out  `NCH*DATA_W`  latched baseline.
- `peak_out`  out  `NCH*DATA_W`  maximum raw sample in the window.
- `peak_idx`  out  `NCH*IDX_W`  window index of that maximum.

## Operation
- Per channel, a presample ring of depth `PRESAMPLE_NUM` and a running sum update every cycle in every state. The ring and sum reset to 0. Running sum = sum in + `data_in` − oldest entry.
- FSM has three states: IDLE, ACC and DONE.
  - IDLE: on `L0`=1, latch baseline = running sum >> log2(`PRESAMPLE_NUM`) (truncating), then go to ACC. The sample on `data_in` in the L0 cycle is not yet accumulated.
  - ACC: each cycle, sum += signed(sample) − baseline, and the window counter increments from 0. If sample > current peak, update the peak and its index; on ties the earliest index wins. The peak is seeded by sample index 0. After index `SAMPLE_NUM`−1 go to DONE.
  - DONE: `out_valid`=1 with all outputs stable. On `out_valid` && `out_ready`, go to IDLE.
- `L0` seen in ACC or DONE is ignored and pulses `l0_drop`. `L0` in the same cycle as the DONE handshake is also dropped.
- Widths: the sum is computed at `SUM_W` signed, and no overflow is possible by construction.
- The presamples before a trigger that comes fewer than `PRESAMPLE_NUM` cycles after reset include zero-filled entries. This is accepted and not flagged.

## Timing
- Presamples are the `data_in` values at cycles t−`PRESAMPLE_NUM`..t−1, where t is the L0 cycle.
- Window sample index k is the `data_in` value at cycle t+1+k.
- `out_valid` rises in cycle t+`SAMPLE_NUM`+1 and stays high until the handshake.
- The earliest cycle a new `L0` can be accepted is the cycle after the handshake.
- Reset values:
  - `busy`, `l0_drop` and `out_valid` are 0.
  - `sum_out`, `base_out`, `peak_out` and `peak_idx` are 0.
  - FSM goes to IDLE and the ring is cleared.
- `rst` during ACC or DONE aborts the event: there is no `out_valid` and the result is lost. Outputs read 0 from the cycle after `rst` is sampled.
- Result registers hold their values after the handshake until the next accumulation overwrites them. They are only meaningful while `out_valid`=1.

## Structure
- Package `sample_sum_pkg`:
  - state enum (IDLE/ACC/DONE);
  - functions for `IDX_W` and `SUM_W`.
- Sub-module `sample_sum_ch` holds one channel's ring, running sum, baseline, accumulator and peak tracker. It is generated `NCH` times.
- The top level holds the shared FSM, window counter, `l0_drop` logic and port packing.

## Test plan
- **Pulse, default parameters.**
  - Stimulus: ch0 presamples 49,51,51,50; L0; window 51,57,279,634,890,1003,1007,949,859,758,657,563,481,411,353,303,262,227,199,177,159,145,131,121.
  - Response: base 50, sum 9476, peak 1007, idx 6, `out_valid` at t+25.
- **Flat input, per-channel offsets.**
  - Stimulus: constant input 100+c on channel c.
  - Response: every channel gives sum 0, base 100+c, peak 100+c, idx 0.
- **Negative sum.**
  - Stimulus: presamples 200; window all 150.
  - Response: sum −1200, peak 150, idx 0.
- **Backpressure.**
  - Stimulus: `out_ready`=0 for 10 cycles after `out_valid`; `L0` pulsed meanwhile.
  - Response: outputs stable, `busy`=1, one `l0_drop` pulse, no second result; the next L0 after the handshake is accepted.
- **Reset mid-ACC.**
  - Stimulus: `rst` at window index 10.
  - Response: `busy`=0 and outputs 0 next cycle, no `out_valid`, ring cleared. A following L0 with zero history gives base 0.
- **Tie and back-to-back.**
  - Stimulus: window with 500 at indices 3 and 8; `out_ready` tied high; L0 re-asserted on the cycle after the handshake.
  - Response: idx 3; the second event is accepted and completes correctly.
